mem_access_ctrl: RTL and testbench

//   Multi-cycle load/store sequencer between the MAR/MDR select muxes and the memory port.

---
 rtl/rv32i_types.sv | 19 +
 rtl/mem_access_ctrl_load_align.sv | 29 ++
 rtl/mem_access_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions.
// Load/store funct3 encodings used by the memory path.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment and extension.
// Shifts the addressed lanes down to bit 0, then sign/zero extends.
module load_align
    import rv32i_types::*;
#(
    parameter int width = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       offset,
    input  logic [width-1:0] mem_rdata,
    output logic [width-1:0] data
);

    logic [width-1:0] shifted;

    // Lane shift followed by funct3-selected extension
    always_comb begin
        shifted = mem_rdata >> {offset, 3'b000};
        data    = shifted;
        case (funct3)
            lb:      data = {{24{shifted[7]}}, shifted[7:0]};
            lh:      data = {{16{shifted[15]}}, shifted[15:0]};
            lbu:     data = {24'd0, shifted[7:0]};
            lhu:     data = {16'd0, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle load/store sequencer towards the memory port.
// Latches the request, runs the strobe handshake, returns aligned load data.
module mem_access_ctrl
    import rv32i_types::*;
#(
    parameter int width   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_read,
    input  logic             req_write,
    input  logic [width-1:0] req_addr,
    input  logic [width-1:0] req_wdata,
    input  logic [2:0]       req_funct3,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [width-1:0] rdata,
    output logic [width-1:0] mem_address,
    output logic             mem_read,
    output logic             mem_write,
    output logic [3:0]       mem_byte_enable,
    output logic [width-1:0] mem_wdata,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_resp
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        FIN,
        FAULT
    } mac_state_t;

    // Counter only needs to reach TIMEOUT-1; the terminal cycle moves to FAULT.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    mac_state_t       state_q, state_d;
    logic [width-1:0] addr_q, addr_d;
    logic [2:0]       f3_q, f3_d;
    logic [3:0]       be_q, be_d;
    logic [width-1:0] wdata_q, wdata_d;
    logic [width-1:0] rdata_q, rdata_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             ld_ok;
    logic             st_ok;
    logic [3:0]       st_be;
    logic [width-1:0] load_word;

    load_align #(.width(width)) u_load_align (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .mem_rdata (mem_rdata),
        .data      (load_word)
    );

    // Request legality and store lane enables
    always_comb begin
        ld_ok = 1'b0;
        st_ok = 1'b0;
        st_be = 4'b0000;
        case (req_funct3)
            lb, lbu:  ld_ok = 1'b1;
            lh, lhu:  ld_ok = ~req_addr[0];
            lw:       ld_ok = (req_addr[1:0] == 2'b00);
            default:  ld_ok = 1'b0;
        endcase
        case (req_funct3)
            sb: begin
                st_ok = 1'b1;
                st_be = 4'b0001 << req_addr[1:0];
            end
            sh: begin
                st_ok = ~req_addr[0];
                st_be = 4'b0011 << req_addr[1:0];
            end
            sw: begin
                st_ok = (req_addr[1:0] == 2'b00);
                st_be = 4'b1111;
            end
            default: st_ok = 1'b0;
        endcase
    end

    // Next-state, request latching, watchdog and load capture
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_read || req_write) begin
                    addr_d  = req_addr;
                    f3_d    = req_funct3;
                    wdata_d = req_wdata << {req_addr[1:0], 3'b000};
                    be_d    = req_write ? st_be : 4'b0000;
                    cnt_d   = '0;
                    if (req_read && req_write) begin
                        state_d = FAULT;
                    end else if (req_read) begin
                        state_d = ld_ok ? RD : FAULT;
                    end else begin
                        state_d = st_ok ? WR : FAULT;
                    end
                end
            end
            RD, WR: begin
                if (mem_resp) begin
                    state_d = FIN;
                    if (state_q == RD) begin
                        rdata_d = load_word;
                    end
                end else if (TIMEOUT != 0 && cnt_q == TLIM) begin
                    state_d = FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FIN);
    assign err             = (state_q == FAULT);
    assign mem_read        = (state_q == RD);
    assign mem_write       = (state_q == WR);
    assign mem_address     = {addr_q[width-1:2], 2'b00};
    assign mem_byte_enable = be_q;
    assign mem_wdata       = wdata_q;
    assign rdata           = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed cases plus randomized accesses
// checked against a size/alignment arithmetic model.
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_read, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        busy, done, err;
    logic [31:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [3:0]  mem_byte_enable;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.width(32), .TIMEOUT(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_read        (req_read),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_funct3      (req_funct3),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .rdata           (rdata),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Access size in bytes; 0 means the funct3 is not a legal encoding.
    function automatic int size_of(input bit is_load, input logic [2:0] f3);
        if (is_load) begin
            case (f3)
                3'd0, 3'd4: return 1;
                3'd1, 3'd5: return 2;
                3'd2:       return 4;
                default:    return 0;
            endcase
        end
        case (f3)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_model(input logic [2:0] f3,
            input int off, input int sz, input logic [31:0] md);
        logic [31:0] v, mask;
        v    = md >> (8 * off);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = v & mask;
        if (f3 < 3'd4 && sz < 4 && v[8 * sz - 1])
            v = v | ~mask;
        return v;
    endfunction

    // One request; delay = strobe cycle index carrying mem_resp (>= TMO: none)
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3,
                          input logic [31:0] md, input int delay);
        int          sz, off, strobes;
        bit          legal, got;
        logic [3:0]  be_e;
        logic [31:0] wd_e;
        off   = int'(a[1:0]);
        sz    = size_of(rd, f3);
        legal = (rd != wr) && (sz != 0) && ((int'(a[1:0]) % (sz == 0 ? 1 : sz)) == 0);
        req_read = rd; req_write = wr;
        req_addr = a; req_wdata = wd; req_funct3 = f3;
        tick();
        req_read = 1'b0; req_write = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        if (!legal) begin
            check("fault_err", err, 1);
            check("fault_busy", busy, 1);
            check("fault_strobe", {mem_read, mem_write, done}, 0);
            tick();
            check("fault_idle", {busy, err, done}, 0);
            check("fault_rdata", rdata, exp_rdata);
            return;
        end
        be_e = rd ? 4'b0000 : 4'(((1 << sz) - 1) << off);
        wd_e = wd << (8 * off);
        strobes = 0;
        got = 1'b0;
        for (int k = 0; k < TMO && !got; k++) begin
            check("strobe", {mem_read, mem_write}, rd ? 2'b10 : 2'b01);
            check("mem_address", mem_address, a & 32'hFFFF_FFFC);
            check("byte_enable", mem_byte_enable, be_e);
            if (wr) check("mem_wdata", mem_wdata, wd_e);
            strobes++;
            if (k == delay) begin
                mem_rdata = md;
                mem_resp = 1'b1;
                got = 1'b1;
            end else begin
                mem_rdata = $urandom;
            end
            tick();
            mem_resp = 1'b0;
            mem_rdata = $urandom;
        end
        check("strobe_cycles", strobes, got ? delay + 1 : TMO);
        if (got) begin
            if (rd) exp_rdata = load_model(f3, off, sz, md);
            check("fin_done", {done, busy, err}, 3'b110);
            check("fin_strobe", {mem_read, mem_write}, 0);
            check("rdata", rdata, exp_rdata);
            tick();
            check("idle_after_fin", {done, busy}, 0);
        end else begin
            check("timeout_err", {err, busy, done}, 3'b110);
            check("timeout_strobe", {mem_read, mem_write}, 0);
            tick();
            mem_resp = 1'b1;
            tick();
            mem_resp = 1'b0;
            check("late_resp", {done, busy, err}, 0);
            check("timeout_rdata", rdata, exp_rdata);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, wd, md;
        int          sel;
        rst_n = 1'b0;
        req_read = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_funct3 = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        tick();
        tick();
        check("reset_ctrl", {busy, done, err, mem_read, mem_write}, 0);
        check("reset_rdata", rdata, 0);
        check("reset_addr", mem_address, 0);
        check("reset_lanes", {mem_byte_enable, mem_wdata}, 0);
        rst_n = 1'b1;
        tick();

        access(1, 0, 32'h100, 32'h0, 3'd2, 32'hDEAD_BEEF, 2);
        access(1, 0, 32'h103, 32'h0, 3'd0, 32'h80FF_0000, 0);
        access(1, 0, 32'h103, 32'h0, 3'd4, 32'h80FF_0000, 1);
        access(0, 1, 32'h202, 32'h0000_ABCD, 3'd1, 32'h0, 1);
        access(1, 0, 32'h101, 32'h0, 3'd2, 32'h0, 0);
        access(1, 1, 32'h100, 32'h0, 3'd2, 32'h0, 0);
        access(1, 0, 32'h104, 32'h0, 3'd2, 32'h1234_5678, TMO);
        access(0, 1, 32'h208, 32'h5555_AAAA, 3'd2, 32'h0, TMO);
        access(1, 0, 32'h102, 32'h0, 3'd1, 32'h8001_0000, 3);
        access(0, 1, 32'h20B, 32'h0000_00C3, 3'd0, 32'h0, 0);

        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            a   = $urandom;
            wd  = $urandom;
            md  = $urandom;
            if (sel < 6) a[1:0] = 2'($urandom_range(0, 3));
            access(sel == 0 || sel < 5, sel == 0 || sel >= 5, a, wd,
                   3'($urandom_range(0, 7)), md, $urandom_range(0, 5));
        end

        req_read = 1'b1; req_addr = 32'h100; req_funct3 = 3'd2;
        tick();
        req_read = 1'b0;
        check("midrd_strobe", mem_read, 1);
        tick();
        rst_n = 1'b0;
        tick();
        exp_rdata = 32'd0;
        check("midrd_reset", {mem_read, busy, done, err}, 0);
        check("midrd_rdata", rdata, exp_rdata);
        rst_n = 1'b1;
        mem_resp = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        tick();
        mem_resp = 1'b0;
        check("stray_resp", {done, busy, err}, 0);
        check("stray_rdata", rdata, exp_rdata);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
